// File: rtl/rv_mem_pkg.sv
// Shared definitions for the RV32 data-memory responder: funct3 access
// encodings, responder FSM states and the data-path width.
package rv_mem_pkg;

  localparam int DATA_W = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WAIT   = 3'd1,
    S_ACCESS = 3'd2,
    S_RDATA  = 3'd3,
    S_RESP   = 3'd4
  } dmem_state_t;

endpackage

// File: rtl/dmem_bram.sv
// Single-port 32-bit RAM with per-byte write enables and one-cycle
// synchronous read. Contents are not reset.
module dmem_bram
  import rv_mem_pkg::*;
#(
  parameter int    ADDR_W    = 10,
  parameter string INIT_FILE = ""
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr,
  input  logic [3:0]        be,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Byte-lane writes and registered read (read returns pre-write data).
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/data_mem_resp.sv
// Data-memory responder for the multi-cycle RV32 core: latches one
// load/store request, optionally inserts wait states, performs the byte,
// half or word access with lane steering and extension, and returns a
// single-cycle ready pulse (with err on rejected requests).
module data_mem_resp
  import rv_mem_pkg::*;
#(
  parameter int    ADDR_W      = 10,
  parameter int    WAIT_CYCLES = 0,
  parameter string INIT_FILE   = ""
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              we,
  input  logic [2:0]        funct3,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              ready,
  output logic              err,
  output logic              busy
);

  dmem_state_t       state_q, state_d;
  logic [3:0]        cnt_q;
  logic [ADDR_W+1:0] addr_q;
  logic              we_q;
  logic [2:0]        f3_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rdata_q;
  logic              err_c;
  logic [3:0]        ram_be;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata;

  // Address bits above the RAM size are ignored so accesses wrap.
  logic unused_addr;
  assign unused_addr = ^addr[31:ADDR_W+2];

  // Reject reserved encodings, sign-extending stores and misalignment.
  function automatic logic access_err(input logic w, input logic [2:0] f3,
                                      input logic [1:0] off);
    case (f3)
      F3_B:    access_err = 1'b0;
      F3_BU:   access_err = w;
      F3_H:    access_err = off[0];
      F3_HU:   access_err = w | off[0];
      F3_W:    access_err = (off != 2'b00);
      default: access_err = 1'b1;
    endcase
  endfunction

  // Byte enables for a store; half stores use the half selected by off[1].
  function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      F3_B:    store_be = 4'b0001 << off;
      F3_H:    store_be = off[1] ? 4'b1100 : 4'b0011;
      F3_W:    store_be = 4'b1111;
      default: store_be = 4'b0000;
    endcase
  endfunction

  // Replicate right-aligned store data onto every lane it may target.
  function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] d);
    case (f3)
      F3_B:    store_data = {4{d[7:0]}};
      F3_H:    store_data = {2{d[15:0]}};
      default: store_data = d;
    endcase
  endfunction

  // Pick the addressed byte/half out of the RAM word and extend it.
  function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [2:0] f3,
                                           input logic [1:0] off);
    logic        [31:0] sh;
    logic signed [7:0]  b;
    logic signed [15:0] h;
    sh = w >> {off, 3'b000};
    b  = sh[7:0];
    h  = off[1] ? w[31:16] : w[15:0];
    case (f3)
      F3_B:    load_ext = {{24{b[7]}}, b};
      F3_BU:   load_ext = {24'd0, b};
      F3_H:    load_ext = {{16{h[15]}}, h};
      F3_HU:   load_ext = {16'd0, h};
      default: load_ext = w;
    endcase
  endfunction

  assign err_c     = access_err(we_q, f3_q, addr_q[1:0]);
  assign ram_wdata = store_data(f3_q, wdata_q);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; requests outside IDLE are ignored.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (req) state_d = (WAIT_CYCLES > 0) ? S_WAIT : S_ACCESS;
      S_WAIT:   if (cnt_q <= 4'd1) state_d = S_ACCESS;
      S_ACCESS: state_d = (we_q || err_c) ? S_RESP : S_RDATA;
      S_RDATA:  state_d = S_RESP;
      S_RESP:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // RAM write strobes only on the ACCESS edge of a legal store.
  always_comb begin
    ram_be = 4'b0000;
    if (state_q == S_ACCESS && we_q && !err_c) ram_be = store_be(f3_q, addr_q[1:0]);
  end

  // Request fields captured once per accepted request.
  always_ff @(posedge clk) begin
    if (state_q == S_IDLE && req) begin
      addr_q  <= addr[ADDR_W+1:0];
      we_q    <= we;
      f3_q    <= funct3;
      wdata_q <= wdata;
    end
  end

  // Wait-state counter, loaded on accept and counted down in WAIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         cnt_q <= 4'd0;
    else if (state_q == S_IDLE && req)  cnt_q <= 4'(WAIT_CYCLES);
    else if (state_q == S_WAIT)         cnt_q <= cnt_q - 4'd1;
  end

  // Load result: cleared on rejected requests, held across stores.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                             rdata_q <= '0;
    else if (state_q == S_ACCESS && err_c)  rdata_q <= '0;
    else if (state_q == S_RDATA)            rdata_q <= load_ext(ram_rdata, f3_q, addr_q[1:0]);
  end

  dmem_bram #(
    .ADDR_W   (ADDR_W),
    .INIT_FILE(INIT_FILE)
  ) u_ram (
    .clk  (clk),
    .addr (addr_q[ADDR_W+1:2]),
    .be   (ram_be),
    .wdata(ram_wdata),
    .rdata(ram_rdata)
  );

  assign rdata = rdata_q;
  assign ready = (state_q == S_RESP);
  assign err   = (state_q == S_RESP) && err_c;
  assign busy  = (state_q != S_IDLE);

endmodule

// File: tb/tb_data_mem_resp.sv
// Directed bench for data_mem_resp: one instance without wait states and
// one with three, driven by a linear request sequence with a scoreboard
// of expected responses.
module tb_data_mem_resp;
  import rv_mem_pkg::*;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req, we, rdy, er, bsy;
  logic [2:0]  f3 [2];
  logic [31:0] a  [2];
  logic [31:0] wd [2];
  logic [31:0] rd [2];

  int          n_cmp = 0;
  int          n_bad = 0;
  int          n_txn [2] = '{0, 0};
  int          rdy_cnt [2] = '{0, 0};
  logic [31:0] last_rd [2] = '{32'd0, 32'd0};
  exp_t        sb_q[$];

  always #5 clk = ~clk;

  data_mem_resp #(.ADDR_W(10), .WAIT_CYCLES(0), .INIT_FILE("")) u_w0 (
    .clk(clk), .rst_n(rst_n), .req(req[0]), .we(we[0]), .funct3(f3[0]),
    .addr(a[0]), .wdata(wd[0]), .rdata(rd[0]), .ready(rdy[0]), .err(er[0]),
    .busy(bsy[0]));

  data_mem_resp #(.ADDR_W(10), .WAIT_CYCLES(3), .INIT_FILE("")) u_w3 (
    .clk(clk), .rst_n(rst_n), .req(req[1]), .we(we[1]), .funct3(f3[1]),
    .addr(a[1]), .wdata(wd[1]), .rdata(rd[1]), .ready(rdy[1]), .err(er[1]),
    .busy(bsy[1]));

  always @(negedge clk) begin
    if (rdy[0] === 1'b1) rdy_cnt[0] <= rdy_cnt[0] + 1;
    if (rdy[1] === 1'b1) rdy_cnt[1] <= rdy_cnt[1] + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int d, input logic r, input logic w, input logic [2:0] f,
                       input logic [31:0] ad, input logic [31:0] dd);
    req[d] = r; we[d] = w; f3[d] = f; a[d] = ad; wd[d] = dd;
  endtask

  // One request: push expectation, issue it, wait for ready, compare.
  task automatic txn(input string tag, input int d, input logic w, input logic [2:0] f,
                     input logic [31:0] ad, input logic [31:0] dd, input logic exp_err,
                     input logic [31:0] ld_val, input bit mid_req);
    exp_t e;
    int   cyc;
    bit   busy_ok;
    e.err = exp_err;
    e.lat = ((d == 1) ? 3 : 0) + ((w || exp_err) ? 2 : 3);
    if (exp_err)  e.rdata = 32'd0;
    else if (w)   e.rdata = last_rd[d];
    else          e.rdata = ld_val;
    last_rd[d] = e.rdata;
    sb_q.push_back(e);
    n_txn[d]++;

    @(negedge clk);
    drive(d, 1'b1, w, f, ad, dd);
    @(negedge clk);
    req[d] = 1'b0;
    cyc = 1;
    busy_ok = 1'b1;
    while (rdy[d] !== 1'b1 && cyc < 40) begin
      if (bsy[d] !== 1'b1) busy_ok = 1'b0;
      req[d] = (mid_req && cyc == 2);
      if (mid_req && cyc == 2) wd[d] = ~dd;
      @(negedge clk);
      cyc++;
    end
    req[d] = 1'b0;

    e = sb_q.pop_front();
    chk({tag, "_ready"}, {31'd0, rdy[d]}, 32'd1);
    chk({tag, "_latency"}, cyc, e.lat);
    chk({tag, "_err"}, {31'd0, er[d]}, {31'd0, e.err});
    chk({tag, "_rdata"}, rd[d], e.rdata);
    chk({tag, "_busy"}, {31'd0, busy_ok && (bsy[d] === 1'b1)}, 32'd1);
    @(negedge clk);
    chk({tag, "_pulse"}, {30'd0, rdy[d], bsy[d]}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 1'b0, 1'b0, F3_W, 32'd0, 32'd0);
    drive(1, 1'b0, 1'b0, F3_W, 32'd0, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("reset_rdata", rd[d], 32'd0);
      chk("reset_ctrl", {29'd0, rdy[d], er[d], bsy[d]}, 32'd0);
    end

    // Word store/load, then byte/half lanes over 0xDEADBEEF.
    txn("sw_10",   0, 1'b1, F3_W,  32'h10, 32'hDEADBEEF, 1'b0, 32'h0,        1'b0);
    txn("lw_10",   0, 1'b0, F3_W,  32'h10, 32'h0,        1'b0, 32'hDEADBEEF, 1'b0);
    txn("sb_11",   0, 1'b1, F3_B,  32'h11, 32'h00000055, 1'b0, 32'h0,        1'b0);
    txn("lw_10b",  0, 1'b0, F3_W,  32'h10, 32'h0,        1'b0, 32'hDEAD55EF, 1'b0);
    txn("lb_13",   0, 1'b0, F3_B,  32'h13, 32'h0,        1'b0, 32'hFFFFFFDE, 1'b0);
    txn("lbu_13",  0, 1'b0, F3_BU, 32'h13, 32'h0,        1'b0, 32'h000000DE, 1'b0);
    txn("lh_12",   0, 1'b0, F3_H,  32'h12, 32'h0,        1'b0, 32'hFFFFDEAD, 1'b0);
    txn("lhu_12",  0, 1'b0, F3_HU, 32'h12, 32'h0,        1'b0, 32'h0000DEAD, 1'b0);

    // Misalignment and illegal encodings.
    txn("lw_12",   0, 1'b0, F3_W,  32'h12, 32'h0,        1'b1, 32'h0,        1'b0);
    txn("sw_20",   0, 1'b1, F3_W,  32'h20, 32'h12345678, 1'b0, 32'h0,        1'b0);
    txn("sh_21",   0, 1'b1, F3_H,  32'h21, 32'h0000AAAA, 1'b1, 32'h0,        1'b0);
    txn("lw_20",   0, 1'b0, F3_W,  32'h20, 32'h0,        1'b0, 32'h12345678, 1'b0);
    txn("f3_011",  0, 1'b0, 3'b011, 32'h20, 32'h0,       1'b1, 32'h0,        1'b0);
    txn("sb_f100", 0, 1'b1, F3_BU, 32'h20, 32'h000000FF, 1'b1, 32'h0,        1'b0);
    txn("lw_20b",  0, 1'b0, F3_W,  32'h20, 32'h0,        1'b0, 32'h12345678, 1'b0);
    txn("sh_22",   0, 1'b1, F3_H,  32'h22, 32'h0000BEEF, 1'b0, 32'h0,        1'b0);
    txn("lw_20c",  0, 1'b0, F3_W,  32'h20, 32'h0,        1'b0, 32'hBEEF5678, 1'b0);
    txn("lb_20",   0, 1'b0, F3_B,  32'h20, 32'h0,        1'b0, 32'h00000078, 1'b0);
    txn("lh_22",   0, 1'b0, F3_H,  32'h22, 32'h0,        1'b0, 32'hFFFFBEEF, 1'b0);

    // Wait states with an ignored mid-operation request.
    txn("w3_sw_40", 1, 1'b1, F3_W, 32'h40, 32'hCAFEF00D, 1'b0, 32'h0,        1'b1);
    txn("w3_lw_40", 1, 1'b0, F3_W, 32'h40, 32'h0,        1'b0, 32'hCAFEF00D, 1'b0);

    // Reset during WAIT of a store: dropped, no ready, RAM untouched.
    @(negedge clk);
    drive(1, 1'b1, 1'b1, F3_W, 32'h40, 32'h0BADBEEF);
    @(negedge clk);
    req[1] = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("rst_no_ready", rdy_cnt[1], n_txn[1]);
    chk("rst_rdata", rd[1], 32'd0);
    chk("rst_busy", {31'd0, bsy[1]}, 32'd0);
    last_rd[0] = 32'd0;
    last_rd[1] = 32'd0;
    txn("w3_lw_40b", 1, 1'b0, F3_W, 32'h40, 32'h0, 1'b0, 32'hCAFEF00D, 1'b0);

    // Address wrap modulo the RAM size.
    txn("w3_sw_1000", 1, 1'b1, F3_W, 32'h1000, 32'h5A5AA5A5, 1'b0, 32'h0,        1'b0);
    txn("w3_lw_0",    1, 1'b0, F3_W, 32'h0,    32'h0,        1'b0, 32'h5A5AA5A5, 1'b0);
    txn("w0_sw_1004", 0, 1'b1, F3_W, 32'h1004, 32'h13579BDF, 1'b0, 32'h0,        1'b0);
    txn("w0_lw_4",    0, 1'b0, F3_W, 32'h4,    32'h0,        1'b0, 32'h13579BDF, 1'b0);

    repeat (4) @(negedge clk);
    chk("ready_count_w0", rdy_cnt[0], n_txn[0]);
    chk("ready_count_w3", rdy_cnt[1], n_txn[1]);
    chk("sb_empty", sb_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
